// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shifter feeding the SIPO receiver; one bit per clock, back-to-back words.
// Optional PISO_PARITY_EN appends an even-parity bit after each word.
module piso_shift_reg #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] pi,
  output logic             ready,
  output logic             so,
  output logic             so_valid,
  output logic             done,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH-1);

`ifdef PISO_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PARITY} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT} state_t;
`endif

  state_t           r_state, w_nxt_state;
  logic [WIDTH-1:0] r_shreg, w_nxt_shreg;
  logic [CW-1:0]    r_cnt,   w_nxt_cnt;
  logic             r_so, r_vld, r_done;
  logic             w_nxt_so, w_nxt_vld, w_nxt_done;
  logic             w_last, w_ready, w_acc, w_head;
`ifdef PISO_PARITY_EN
  logic             r_par, w_nxt_par;
`endif

  assign w_last = (r_state == S_SHIFT) && (r_cnt == LAST);
  assign w_head = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
`ifdef PISO_PARITY_EN
  assign w_ready = (r_state == S_IDLE) || (r_state == S_PARITY);
`else
  assign w_ready = (r_state == S_IDLE) || w_last;
`endif
  assign w_acc = load && w_ready;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_shreg = r_shreg;
    w_nxt_cnt   = r_cnt;
    w_nxt_so    = 1'b0;
    w_nxt_vld   = 1'b0;
    w_nxt_done  = 1'b0;
`ifdef PISO_PARITY_EN
    w_nxt_par   = r_par;
`endif
    if (w_acc) begin
      // First bit goes straight to so; shreg keeps only the remaining bits.
      w_nxt_state = S_SHIFT;
      w_nxt_cnt   = '0;
      w_nxt_vld   = 1'b1;
      w_nxt_so    = MSB_FIRST ? pi[WIDTH-1] : pi[0];
      w_nxt_shreg = MSB_FIRST ? (pi << 1) : (pi >> 1);
`ifdef PISO_PARITY_EN
      w_nxt_par   = ^pi;
`endif
    end else begin
      case (r_state)
        S_SHIFT: begin
          if (!w_last) begin
            w_nxt_cnt   = r_cnt + CW'(1);
            w_nxt_shreg = MSB_FIRST ? (r_shreg << 1) : (r_shreg >> 1);
            w_nxt_so    = w_head;
            w_nxt_vld   = 1'b1;
`ifndef PISO_PARITY_EN
            w_nxt_done  = (w_nxt_cnt == LAST);
`endif
          end else begin
`ifdef PISO_PARITY_EN
            w_nxt_state = S_PARITY;
            w_nxt_so    = r_par;
            w_nxt_vld   = 1'b1;
            w_nxt_done  = 1'b1;
`else
            w_nxt_state = S_IDLE;
`endif
          end
        end
`ifdef PISO_PARITY_EN
        S_PARITY: w_nxt_state = S_IDLE;
`endif
        default: w_nxt_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
      r_so    <= 1'b0;
      r_vld   <= 1'b0;
      r_done  <= 1'b0;
`ifdef PISO_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_nxt_state;
      r_shreg <= w_nxt_shreg;
      r_cnt   <= w_nxt_cnt;
      r_so    <= w_nxt_so;
      r_vld   <= w_nxt_vld;
      r_done  <= w_nxt_done;
`ifdef PISO_PARITY_EN
      r_par   <= w_nxt_par;
`endif
    end
  end

  assign ready    = w_ready;
  assign so       = r_so;
  assign so_valid = r_vld;
  assign done     = r_done;
  assign busy     = (r_state != S_IDLE);
endmodule

// File: tb/tb_piso_shift_reg.sv
// Random + directed bench; two DUTs (MSB-first and LSB-first) checked against a bit-queue model.
module tb_piso_shift_reg;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] pi = '0;
  logic         rdy_m, so_m, vld_m, done_m, busy_m;
  logic         rdy_l, so_l, vld_l, done_l, busy_l;

  int n_chk  = 0;
  int n_fail = 0;

  // Model: queue of bits still to appear on so; head is the bit currently shown.
  bit qm[$];
  bit ql[$];

  always #5 clk = ~clk;

  piso_shift_reg #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .load(load), .pi(pi),
    .ready(rdy_m), .so(so_m), .so_valid(vld_m), .done(done_m), .busy(busy_m));

  piso_shift_reg #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .load(load), .pi(pi),
    .ready(rdy_l), .so(so_l), .so_valid(vld_l), .done(done_l), .busy(busy_l));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    bit eso_m = (qm.size() > 0) ? qm[0] : 1'b0;
    bit eso_l = (ql.size() > 0) ? ql[0] : 1'b0;
    chk("msb_so",    32'(so_m),   32'(eso_m));
    chk("msb_vld",   32'(vld_m),  32'(qm.size() > 0));
    chk("msb_done",  32'(done_m), 32'(qm.size() == 1));
    chk("msb_busy",  32'(busy_m), 32'(qm.size() > 0));
    chk("msb_ready", 32'(rdy_m),  32'(qm.size() <= 1));
    chk("lsb_so",    32'(so_l),   32'(eso_l));
    chk("lsb_vld",   32'(vld_l),  32'(ql.size() > 0));
    chk("lsb_done",  32'(done_l), 32'(ql.size() == 1));
    chk("lsb_busy",  32'(busy_l), 32'(ql.size() > 0));
    chk("lsb_ready", 32'(rdy_l),  32'(ql.size() <= 1));
  endtask

  task automatic step(input logic ld, input logic [W-1:0] d);
    bit acc;
    load = ld;
    pi   = d;
    @(posedge clk);
    if (rst) begin
      acc = ld && (qm.size() <= 1);
      if (qm.size() > 0) void'(qm.pop_front());
      if (ql.size() > 0) void'(ql.pop_front());
      if (acc) begin
        for (int i = W-1; i >= 0; i--) qm.push_back(d[i]);
        for (int i = 0; i < W; i++)    ql.push_back(d[i]);
`ifdef PISO_PARITY_EN
        qm.push_back(^d);
        ql.push_back(^d);
`endif
      end
    end
    #1;
    check_all();
  endtask

  // Reset dropped between clock edges, not aligned to either.
  task automatic async_reset();
    #3 rst = 1'b0;
    #1;
    qm.delete();
    ql.delete();
    check_all();
    step(1'b1, 4'b1111);
    step(1'b1, 4'b0101);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    #1;
    check_all();
    step(1'b0, '0);
    step(1'b1, 4'b1010);
    rst = 1'b1;
    // Test 1/2: single words, both bit orders
    step(1'b1, 4'b1010);
    repeat (5) step(1'b0, 4'b0000);
    step(1'b1, 4'b1101);
    repeat (5) step(1'b0, '0);
    // Test 3: back-to-back with load held on the ready cycle
    step(1'b1, 4'b1010);
    for (int i = 0; i < W-1; i++) step(1'b0, '0);
`ifdef PISO_PARITY_EN
    step(1'b0, '0);
`endif
    step(1'b1, 4'b0110);
    repeat (6) step(1'b0, '0);
    // Test 4: load mid-word ignored
    step(1'b1, 4'b1010);
    step(1'b1, 4'b1111);
    repeat (5) step(1'b0, '0);
    // Test 5: async reset mid-word, then clean word
    step(1'b1, 4'b1100);
    step(1'b0, '0);
    async_reset();
    step(1'b1, 4'b0011);
    repeat (5) step(1'b0, '0);
    // Parity patterns
    step(1'b1, 4'b1011);
    step(1'b0, '0);
    repeat (4) step(1'b0, '0);
    step(1'b1, 4'b1001);
    repeat (6) step(1'b0, '0);
    // Random traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) < 2) async_reset();
      else step(1'($urandom_range(0, 99) < 60), W'($urandom));
    end
    repeat (6) step(1'b0, '0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/piso_shift_reg.md
Name: piso_shift_reg

Overview:
Parallel-in serial-out shift register: the transmit end of the team's serial-in parallel-out link.
- Accepts a WIDTH-bit word on a load/ready handshake and emits it one bit per clock on so, qualified by so_valid.
- Pulses done with the final bit.
- Sits upstream of the existing 4-bit SIPO receiver; supports back-to-back words with no idle gap.

Parameters:
WIDTH, 4, word width in bits (min 2)
MSB_FIRST, 1, 1 = pi[WIDTH-1] sent first; 0 = pi[0] sent first

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
load  input  1  request to accept pi this cycle
pi  input  WIDTH  parallel data word
ready  output  1  block can accept a load this cycle (combinational from state)
so  output  1  serial data out (registered)
so_valid  output  1  so carries a valid data bit (registered)
done  output  1  one-cycle pulse while the last bit of a word is on so (registered)
busy  output  1  word in transmission (state != IDLE)

Behaviour:
- Reset (rst=0, asynchronous, any time including mid-word):
  - state=IDLE; shreg=0; bit counter cnt=0.
  - so=0, so_valid=0, done=0, busy=0, ready=1.
  - A word in flight is discarded, with no partial done.
- States:
  - IDLE: ready=1, so=0, so_valid=0.
  - SHIFT: a word is being sent.
  - (PARITY: only with the optional feature.)
- Accept rule: a load is taken on a rising edge where load=1 && ready=1. In SHIFT, ready=1 only on the last-bit cycle (cnt==WIDTH-1); otherwise ready=0 and load is ignored, with the word unchanged.
- Latency: on the accept edge, so is set to the first bit, so_valid=1, cnt=0, and state becomes SHIFT. The first bit is visible in the cycle after the load edge.
- Each following edge in SHIFT: shreg shifts toward the output end and cnt increments. so presents bits in order (MSB_FIRST=1: pi[WIDTH-1]..pi[0]; MSB_FIRST=0: pi[0]..pi[WIDTH-1]). Each bit is held exactly one cycle.
- cnt width: $clog2(WIDTH); cnt wraps to 0 on accept only.
- done=1 exactly during the cycle cnt==WIDTH-1, which is the last bit.
- End of word, on the edge after the last bit:
  - If load=1, the new word is accepted with no gap: so_valid stays 1, the new first bit appears, and state remains SHIFT.
  - Else state becomes IDLE with so=0, so_valid=0, done=0.
- Changes on pi while busy have no effect; the word is captured only at accept.
- load asserted while rst=0 is ignored.

Optional Feature:
PISO_PARITY_EN
- Defined:
  - After the last data bit, one extra cycle in state PARITY drives so = even parity (XOR of the captured word), with so_valid=1.
  - done moves to the parity cycle, and ready=1 only in the parity cycle (not in the last data bit).
  - A word occupies WIDTH+1 cycles.
- Undefined: no PARITY state; a word occupies WIDTH cycles, as above.

Test Plan:
1. WIDTH=4, MSB_FIRST=1, rst low 2 cycles, then load=1 with pi=4'b1010 for one edge -> so=1,0,1,0 on the next 4 cycles; so_valid=1 for those 4 cycles; done=1 only on the 4th; then IDLE with so=0, so_valid=0, ready=1.
2. MSB_FIRST=0, pi=4'b1101 -> so=1,0,1,1; done on the 4th bit.
3. Back-to-back: load 4'b1010, hold load=1 with pi=4'b0110 during the done cycle -> so=1,0,1,0,0,1,1,0 continuously; so_valid is never low between words; done pulses twice.
4. Load during shift: load 4'b1010, assert load with pi=4'b1111 on the 2nd bit cycle -> ignored; ready=0; output stays 1,0,1,0; returns to IDLE.
5. Reset mid-word: load 4'b1100, drop rst after the 2nd bit, asynchronously (not clock-aligned) -> so, so_valid, done, and busy go 0 immediately; ready=1; no done pulse; a subsequent load 4'b0011 sends 0,0,1,1 correctly.
6. PISO_PARITY_EN defined: pi=4'b1011 -> so=1,0,1,1 then parity 1; done on the 5th cycle. pi=4'b1001 -> parity bit 0.
